// File: rtl/drp_rmw_seq.sv
// drp_rmw_seq: holds the MMCM in reset, walks a read-modify-write table over DRP, then waits for lock.
// Optional macro DRP_READBACK_VERIFY_EN adds a readback compare of every written word.
module drp_rmw_seq #(
    parameter int NUM_ENTRIES  = 4,
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 16,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                          clkin,
    input  logic                          reset,
    input  logic                          drp_start,
    input  logic [NUM_ENTRIES*ADDR_W-1:0] cfg_addr,
    input  logic [NUM_ENTRIES*DATA_W-1:0] cfg_mask,
    input  logic [NUM_ENTRIES*DATA_W-1:0] cfg_data,
    output logic                          drp_den,
    output logic                          drp_dwe,
    output logic [ADDR_W-1:0]             drp_daddr,
    output logic [DATA_W-1:0]             drp_di,
    input  logic [DATA_W-1:0]             drp_do,
    input  logic                          drp_drdy,
    output logic                          mmcm_rst,
    input  logic                          mmcm_locked,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
`ifdef DRP_READBACK_VERIFY_EN
        S_VFY_REQ,
        S_VFY_WAIT,
`endif
        S_NEXT,
        S_LOCK_WAIT,
        S_DONE
    } state_t;

    // Shared wait counter: saturates at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_merged, w_merged_nxt;
    logic                r_den, w_den_nxt;
    logic                r_dwe, w_dwe_nxt;
    logic [ADDR_W-1:0]   r_daddr, w_daddr_nxt;
    logic [DATA_W-1:0]   r_di, w_di_nxt;
    logic                r_rst, w_rst_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;

    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W-1:0]   w_merged;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_drdy_to;
    logic                w_lock_to;

    assign w_addr    = cfg_addr[r_idx*ADDR_W +: ADDR_W];
    assign w_mask    = cfg_mask[r_idx*DATA_W +: DATA_W];
    assign w_data    = cfg_data[r_idx*DATA_W +: DATA_W];
    assign w_merged  = (drp_do & w_mask) | (w_data & ~w_mask);
    assign w_cnt_inc = sat_inc(r_cnt);
    assign w_drdy_to = (w_cnt_inc == CNT_W'(DRDY_TIMEOUT));
    assign w_lock_to = (w_cnt_inc == CNT_W'(LOCK_TIMEOUT));

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_merged_nxt = r_merged;
        w_den_nxt    = 1'b0;
        w_dwe_nxt    = 1'b0;
        w_daddr_nxt  = r_daddr;
        w_di_nxt     = r_di;
        w_rst_nxt    = r_rst;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_error_nxt  = r_error;
        case (r_state)
            S_IDLE: begin
                if (drp_start) begin
                    w_busy_nxt  = 1'b1;
                    w_rst_nxt   = 1'b1;
                    w_error_nxt = 1'b0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_den_nxt   = 1'b1;
                w_daddr_nxt = w_addr;
                w_cnt_nxt   = '0;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    w_merged_nxt = w_merged;
                    w_state_nxt  = S_WR_REQ;
                end else if (w_drdy_to) begin
                    w_error_nxt = 1'b1;
                    w_rst_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WR_REQ: begin
                w_den_nxt   = 1'b1;
                w_dwe_nxt   = 1'b1;
                w_daddr_nxt = w_addr;
                w_di_nxt    = r_merged;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (drp_drdy) begin
`ifdef DRP_READBACK_VERIFY_EN
                    w_state_nxt = S_VFY_REQ;
`else
                    w_state_nxt = S_NEXT;
`endif
                end else if (w_drdy_to) begin
                    w_error_nxt = 1'b1;
                    w_rst_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
`ifdef DRP_READBACK_VERIFY_EN
            S_VFY_REQ: begin
                w_den_nxt   = 1'b1;
                w_daddr_nxt = w_addr;
                w_cnt_nxt   = '0;
                w_state_nxt = S_VFY_WAIT;
            end
            S_VFY_WAIT: begin
                if (drp_drdy && (drp_do == r_merged)) begin
                    w_state_nxt = S_NEXT;
                end else if (drp_drdy || w_drdy_to) begin
                    w_error_nxt = 1'b1;
                    w_rst_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
`endif
            S_NEXT: begin
                if (r_idx == LAST_IDX) begin
                    w_rst_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOCK_WAIT;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_LOCK_WAIT: begin
                if (mmcm_locked) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_lock_to) begin
                    w_error_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_merged <= '0;
            r_den    <= 1'b0;
            r_dwe    <= 1'b0;
            r_daddr  <= '0;
            r_di     <= '0;
            r_rst    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_merged <= w_merged_nxt;
            r_den    <= w_den_nxt;
            r_dwe    <= w_dwe_nxt;
            r_daddr  <= w_daddr_nxt;
            r_di     <= w_di_nxt;
            r_rst    <= w_rst_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
        end
    end

    assign drp_den   = r_den;
    assign drp_dwe   = r_dwe;
    assign drp_daddr = r_daddr;
    assign drp_di    = r_di;
    assign mmcm_rst  = r_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_drp_rmw_seq.sv
// tb_drp_rmw_seq: scoreboard bench with a DRP slave, an MMCM lock model and a table-level reference model.
`timescale 1ns/1ps
module tb_drp_rmw_seq;
    localparam int N  = 2;
    localparam int AW = 7;
    localparam int DW = 16;
`ifdef DRP_READBACK_VERIFY_EN
    localparam int ACC_PER = 3;
    localparam int ACC_CORRUPT = 3;
`else
    localparam int ACC_PER = 2;
    localparam int ACC_CORRUPT = 2 * N;
`endif

    logic            clk = 1'b0;
    logic            reset, drp_start;
    logic [N*AW-1:0] cfg_addr;
    logic [N*DW-1:0] cfg_mask, cfg_data;
    logic            drp_den, drp_dwe, drp_drdy;
    logic [AW-1:0]   drp_daddr;
    logic [DW-1:0]   drp_di, drp_do;
    logic            mmcm_rst, mmcm_locked, busy, done, error;

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    drp_rmw_seq #(.NUM_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW),
                  .DRDY_TIMEOUT(255), .LOCK_TIMEOUT(100)) dut (
        .clkin(clk), .reset(reset), .drp_start(drp_start),
        .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
        .busy(busy), .done(done), .error(error)
    );

    logic [DW-1:0] mem     [0:127];
    logic [DW-1:0] ref_mem [0:127];
    int lat_min = 1, lat_max = 3, lock_delay = 5;
    bit noresp_rd = 0, noresp_wr = 0, corrupt_vfy = 0;

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
    acc_t exp_acc[$];
    bit   exp_done[$];
    int checks = 0, errors = 0;
    int n_den = 0, n_done = 0, t_den = 0, t_done = 0, t_rstfall = 0;
    bit last_we = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=absent required=present", name);
    endtask

    // DRP slave: answers each access after a random latency unless told to stay silent.
    initial begin : drp_slave
        logic we;
        logic [AW-1:0] a, last_wr_a;
        logic [DW-1:0] d;
        bit last_wr_v;
        drp_drdy = 1'b0;
        drp_do = '0;
        last_wr_v = 0;
        last_wr_a = '0;
        forever begin
            @(negedge clk);
            if (drp_den && !reset) begin
                we = drp_dwe;
                a = drp_daddr;
                d = drp_di;
                if (we && noresp_wr) begin
                    noresp_wr = 0;
                    last_wr_v = 0;
                end else if (!we && noresp_rd) begin
                    noresp_rd = 0;
                    last_wr_v = 0;
                end else begin
                    repeat ($urandom_range(lat_max, lat_min)) @(negedge clk);
                    if (we) begin
                        mem[a] = d;
                        last_wr_v = 1;
                        last_wr_a = a;
                    end else begin
                        drp_do = mem[a];
                        if (corrupt_vfy && last_wr_v && last_wr_a == a) begin
                            drp_do = '0;
                            corrupt_vfy = 0;
                        end
                        last_wr_v = 0;
                    end
                    drp_drdy = 1'b1;
                    @(negedge clk);
                    drp_drdy = 1'b0;
                end
            end
        end
    end

    initial begin : lock_model
        int lcnt;
        mmcm_locked = 1'b0;
        lcnt = 0;
        forever begin
            @(negedge clk);
            if (mmcm_rst || reset) begin
                mmcm_locked = 1'b0;
                lcnt = 0;
            end else if (lock_delay >= 0 && !mmcm_locked) begin
                if (lcnt == lock_delay) mmcm_locked = 1'b1;
                else lcnt++;
            end
        end
    end

    initial begin : monitor
        acc_t e;
        bit prev_rst, busy_chk;
        prev_rst = 0;
        busy_chk = 0;
        forever begin
            @(negedge clk);
            if (busy_chk) begin
                chk("busy_after_done", 32'(busy), 32'(0));
                busy_chk = 0;
            end
            if (!mmcm_rst && prev_rst) t_rstfall = cyc;
            prev_rst = mmcm_rst;
            if (drp_den) begin
                n_den++;
                t_den = cyc;
                last_we = drp_dwe;
                chk("rst_held_during_access", 32'(mmcm_rst), 32'(1));
                if (exp_acc.size() == 0) fail("unexpected_access");
                else begin
                    e = exp_acc.pop_front();
                    chk("acc_we", 32'(drp_dwe), 32'(e.we));
                    chk("acc_addr", 32'(drp_daddr), 32'(e.addr));
                    if (e.we) chk("acc_wdata", 32'(drp_di), 32'(e.data));
                end
            end
            if (done) begin
                n_done++;
                t_done = cyc;
                busy_chk = 1;
                chk("rst_low_at_done", 32'(mmcm_rst), 32'(0));
                chk("busy_at_done", 32'(busy), 32'(1));
                chk("missing_accesses", 32'(exp_acc.size()), 32'(0));
                if (exp_done.size() == 0) fail("unexpected_done");
                else chk("done_error", 32'(error), 32'(exp_done.pop_front()));
            end
        end
    end

    // Reference: kind 0 ok, 1 first read silent, 2 never locks, 3 readback corrupted.
    task automatic model_push(input int kind);
        logic [AW-1:0] a;
        logic [DW-1:0] k, dt, m;
        for (int i = 0; i < N; i++) begin
            a  = cfg_addr[i*AW +: AW];
            k  = cfg_mask[i*DW +: DW];
            dt = cfg_data[i*DW +: DW];
            exp_acc.push_back('{we: 1'b0, addr: a, data: '0});
            if (kind == 1) begin
                exp_done.push_back(1'b1);
                return;
            end
            m = (ref_mem[a] & k) | (dt & ~k);
            ref_mem[a] = m;
            exp_acc.push_back('{we: 1'b1, addr: a, data: m});
`ifdef DRP_READBACK_VERIFY_EN
            exp_acc.push_back('{we: 1'b0, addr: a, data: '0});
            if (kind == 3) begin
                exp_done.push_back(1'b1);
                return;
            end
`endif
        end
        exp_done.push_back(kind == 2);
    endtask

    task automatic rand_cfg();
        logic [AW-1:0] a0, a1;
        a0 = AW'($urandom);
        a1 = a0 ^ AW'($urandom_range(127, 1));
        cfg_addr = {a1, a0};
        cfg_mask = {DW'($urandom), DW'($urandom)};
        cfg_data = {DW'($urandom), DW'($urandom)};
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        drp_start = 1'b1;
        s = cyc;
        @(negedge clk);
        drp_start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k = 0;
        while (n_done == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_done == n0) fail("done_timeout");
    endtask

    task automatic wait_den(input int d0, input int budget);
        int k = 0;
        while (n_den == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_den == d0) fail("den_timeout");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_den"}, 32'(drp_den), 32'(0));
        chk({tag, "_dwe"}, 32'(drp_dwe), 32'(0));
        chk({tag, "_daddr"}, 32'(drp_daddr), 32'(0));
        chk({tag, "_di"}, 32'(drp_di), 32'(0));
        chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_error"}, 32'(error), 32'(0));
    endtask

    initial begin : stim
        int s, n0, d0, tr, k;
        logic [DW-1:0] saved [0:127];
        reset = 1'b1;
        drp_start = 1'b0;
        cfg_addr = '0;
        cfg_mask = '0;
        cfg_data = '0;
        for (int i = 0; i < 128; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Directed table: 0x1234 read from 0x08 must come back as a 0x1ABC write.
        mem[7'h08] = 16'h1234;
        ref_mem[7'h08] = 16'h1234;
        cfg_addr = {7'h21, 7'h08};
        cfg_mask = {16'h00FF, 16'hF000};
        cfg_data = {16'h5500, 16'h0ABC};
        model_push(0);
        n0 = n_done; d0 = n_den;
        pulse_start(s);
        wait_den(d0, 20);
        chk("start_to_den_cycles", 32'(t_den - s), 32'(2));
        wait_done(n0, 3000);
        chk("t1_mem08", 32'(mem[7'h08]), 32'h1ABC);
        chk("t1_accesses", 32'(n_den - d0), 32'(ACC_PER * N));

        // First read never answered.
        rand_cfg();
        noresp_rd = 1;
        model_push(1);
        n0 = n_done; d0 = n_den;
        pulse_start(s);
        wait_den(d0, 20);
        tr = t_den;
        wait_done(n0, 400);
        chk("rd_timeout_cycles", 32'(t_done - tr), 32'(255));
        chk("t2_accesses", 32'(n_den - d0), 32'(1));
        @(negedge clk);
        chk("error_sticky_idle", 32'(error), 32'(1));

        // Extra starts during RD_WAIT and on the done cycle are ignored.
        rand_cfg();
        lat_min = 4; lat_max = 4;
        model_push(0);
        n0 = n_done; d0 = n_den;
        pulse_start(s);
        wait_den(d0, 20);
        @(negedge clk);
        drp_start = 1'b1;
        chk("error_cleared_on_start", 32'(error), 32'(0));
        @(negedge clk);
        drp_start = 1'b0;
        lat_min = 1; lat_max = 3;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!mmcm_locked && k < 3000);
        if (!mmcm_locked) fail("lock_timeout_wait");
        @(negedge clk);
        drp_start = 1'b1;
        chk("done_with_start", 32'(done), 32'(1));
        @(negedge clk);
        drp_start = 1'b0;
        repeat (30) @(negedge clk);
        chk("t3_done_count", 32'(n_done - n0), 32'(1));
        chk("t3_accesses", 32'(n_den - d0), 32'(ACC_PER * N));
        chk("t3_idle_busy", 32'(busy), 32'(0));

        // Lock never arrives.
        rand_cfg();
        lock_delay = -1;
        model_push(2);
        n0 = n_done;
        pulse_start(s);
        wait_done(n0, 3000);
        chk("lock_timeout_cycles", 32'(t_done - t_rstfall), 32'(100));
        lock_delay = 5;

        // Reset while a write is outstanding, then a clean run.
        rand_cfg();
        for (int i = 0; i < 128; i++) saved[i] = ref_mem[i];
        noresp_wr = 1;
        model_push(0);
        d0 = n_den;
        pulse_start(s);
        wait_den(d0, 20);
        wait_den(d0 + 1, 20);
        chk("t5_write_seen", 32'(last_we), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        exp_acc.delete();
        exp_done.delete();
        for (int i = 0; i < 128; i++) ref_mem[i] = saved[i];
        model_push(0);
        n0 = n_done; d0 = n_den;
        pulse_start(s);
        wait_done(n0, 3000);
        chk("t5_accesses", 32'(n_den - d0), 32'(ACC_PER * N));

        // Readback corrupted to zero.
        rand_cfg();
        corrupt_vfy = 1;
        model_push(3);
        n0 = n_done; d0 = n_den;
        pulse_start(s);
        wait_done(n0, 3000);
        chk("t6_accesses", 32'(n_den - d0), 32'(ACC_CORRUPT));
        corrupt_vfy = 0;

        // Random tables, latencies and lock delays.
        for (int r = 0; r < 8; r++) begin
            rand_cfg();
            lat_max = $urandom_range(5, 1);
            lock_delay = $urandom_range(20, 0);
            model_push(0);
            n0 = n_done; d0 = n_den;
            pulse_start(s);
            wait_done(n0, 3000);
            chk("rand_accesses", 32'(n_den - d0), 32'(ACC_PER * N));
        end

        repeat (5) @(negedge clk);
        chk("final_exp_acc_empty", 32'(exp_acc.size()), 32'(0));
        chk("final_exp_done_empty", 32'(exp_done.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
